// File: rtl/dac_enc_pkg.sv
// Shared constants, types and encoding helpers for the segmented DAC encoder.
// A 12-bit unsigned code splits into a 5-bit unary count m (0..17 cells) and a
// 7-bit binary LSB field l. Any m above the cell count saturates to full scale.
package dac_enc_pkg;

    localparam int BIN_W      = 7;
    localparam int THERM_W    = 17;
    localparam int DATA_W     = BIN_W + 5;
    localparam int M_W        = DATA_W - BIN_W;
    localparam int PTR_W      = 5;
    localparam int FIFO_DEPTH = 4;
    localparam int LVL_W      = 3;

    // Index 0 is the leftmost bit: MSB of the binary field, physical cell 0.
    typedef logic [0:BIN_W-1]   bin_t;
    typedef logic [0:THERM_W-1] therm_t;

    typedef struct packed {
        logic [M_W-1:0]   m;
        logic [BIN_W-1:0] l;
        logic             sat;
    } split_t;

    function automatic split_t sat_split(input logic [DATA_W-1:0] code);
        split_t s;
        s.m   = code[DATA_W-1:BIN_W];
        s.l   = code[BIN_W-1:0];
        s.sat = 1'b0;
        if (s.m > M_W'(THERM_W)) begin
            s.m   = M_W'(THERM_W);
            s.l   = '1;
            s.sat = 1'b1;
        end
        return s;
    endfunction

    // Cell i is on when its circular distance from the pointer is below m.
    // The wrapped distance is formed as i + (THERM_W - p) so every
    // intermediate value stays inside PTR_W bits.
    function automatic therm_t dwa_mask(input logic [PTR_W-1:0] p,
                                        input logic [M_W-1:0]   m);
        therm_t           mask;
        logic [PTR_W-1:0] off;
        mask = '0;
        for (int i = 0; i < THERM_W; i++) begin
            if (PTR_W'(i) >= p)
                off = PTR_W'(i) - p;
            else
                off = PTR_W'(i) + (PTR_W'(THERM_W) - p);
            mask[i] = (off < m);
        end
        return mask;
    endfunction

endpackage

// File: rtl/dac_enc_fifo.sv
// Small synchronous FIFO buffering input codes ahead of the encoder.
// Ports: clkin/rst (sync, active-high, also used as flush), push_i/wdata_i
// write side, pop_i/rdata_o read side (rdata_o shows the head while not
// empty), level_o occupancy, empty_o/full_o status. Push when full and pop
// when empty are ignored.
module dac_enc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12,
    parameter int LW    = 3
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [LW-1:0]    level_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == LW'(DEPTH));
    assign level_o = cnt_q;
    assign rdata_o = mem_q[rd_q];

    always_comb begin
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
        cnt_d   = cnt_q;
        if (do_push && !do_pop)
            cnt_d = cnt_q + 1'b1;
        else if (do_pop && !do_push)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries data only; validity is tracked by the counters.
    always_ff @(posedge clkin) begin
        if (do_push)
            mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/dac_segment_encoder.sv
// Segmented current-steering DAC front end.
// Ports: clkin/rst (sync, active-high), pdb power-down bar, s_valid/s_ready/
// s_code input stream, datainbin/datainbinb binary LSB pair, dataintherm/
// datainthermb unary cell pair (index = physical cell), sat clamp flag for
// the current word, underflow sticky empty-on-update flag, fifo_level.
// Every pdb=1 edge pops one code (if any) and registers its encoding.
module dac_segment_encoder
    import dac_enc_pkg::*;
#(
    parameter int DWA_EN = 1
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic              pdb,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_code,
    output logic [0:BIN_W-1]  datainbin,
    output logic [0:BIN_W-1]  datainbinb,
    output logic [0:THERM_W-1] dataintherm,
    output logic [0:THERM_W-1] datainthermb,
    output logic              sat,
    output logic              underflow,
    output logic [LVL_W-1:0]  fifo_level
);

    logic              fifo_clr, fifo_empty, fifo_full, push, pop;
    logic [DATA_W-1:0] head;

    split_t            split;
    bin_t              bin_d, bin_q, binb_q;
    therm_t            mask_d, therm_q, thermb_q;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W:0]    ptr_sum;
    logic              sat_q, underflow_q;

    // Power-down flushes the buffer through the FIFO's own sync clear.
    assign fifo_clr = rst || !pdb;
    assign s_ready  = !rst && pdb && !fifo_full;
    assign push     = s_valid && s_ready;
    assign pop      = !rst && pdb && !fifo_empty;

    dac_enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W),
        .LW    (LVL_W)
    ) u_fifo (
        .clkin   (clkin),
        .rst     (fifo_clr),
        .push_i  (push),
        .wdata_i (s_code),
        .pop_i   (pop),
        .rdata_o (head),
        .level_o (fifo_level),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_comb begin
        split   = sat_split(head);
        bin_d   = bin_t'(split.l);
        mask_d  = dwa_mask((DWA_EN != 0) ? ptr_q : '0, split.m);
        ptr_sum = {1'b0, ptr_q} + {1'b0, split.m};
        ptr_d   = ptr_q;
        // Full scale lights every cell, so the rotation origin is kept.
        if (DWA_EN != 0 && split.m != M_W'(THERM_W)) begin
            if (ptr_sum >= (PTR_W+1)'(THERM_W))
                ptr_d = PTR_W'(ptr_sum - (PTR_W+1)'(THERM_W));
            else
                ptr_d = ptr_sum[PTR_W-1:0];
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            bin_q       <= '0;
            binb_q      <= '1;
            therm_q     <= '0;
            thermb_q    <= '1;
            sat_q       <= 1'b0;
            underflow_q <= 1'b0;
            ptr_q       <= '0;
        end else if (!pdb) begin
            bin_q    <= '0;
            binb_q   <= '1;
            therm_q  <= '0;
            thermb_q <= '1;
            sat_q    <= 1'b0;
            ptr_q    <= '0;
        end else if (fifo_empty) begin
            underflow_q <= 1'b1;
        end else begin
            bin_q    <= bin_d;
            binb_q   <= ~bin_d;
            therm_q  <= mask_d;
            thermb_q <= ~mask_d;
            sat_q    <= split.sat;
            ptr_q    <= ptr_d;
        end
    end

    assign datainbin    = bin_q;
    assign datainbinb   = binb_q;
    assign dataintherm  = therm_q;
    assign datainthermb = thermb_q;
    assign sat          = sat_q;
    assign underflow    = underflow_q;

endmodule
